cordic_top: RTL and testbench

CORDIC_TOP -- requirements
Module: cordic_top

---
 rtl/cordic_top.sv | 137 +++++++++++++
 tb/tb_cordic_top.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_top.sv
// Rotation-mode CORDIC producing sin or cos of a Q16.16 degree angle, one iteration per clock.
// Optional quadrant folding to [-180,+180) is enabled by defining CORDIC_QUADRANT_FOLD_EN.
module cordic_top #(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] theta_deg,
    output logic signed [WIDTH-1:0] result_out,
    output logic                    done
);
    // state | meaning
    // IDLE  | waiting for start after reset
    // ITER  | 16 rotation steps, then result write
    // DONE  | result_out valid, waiting for next start
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    localparam logic signed [WIDTH-1:0] DEG90  = WIDTH'(5898240);
    localparam logic signed [WIDTH-1:0] INV_K  = WIDTH'(39797);
`ifdef CORDIC_QUADRANT_FOLD_EN
    localparam logic signed [WIDTH-1:0] DEG180 = WIDTH'(11796480);
`endif

    state_t                  state;
    logic signed [WIDTH-1:0] x, y, z;
    logic [4:0]              cnt;
    logic                    mode_q;
    logic signed [WIDTH-1:0] angle_in;
    logic signed [WIDTH-1:0] x_res;
`ifdef CORDIC_QUADRANT_FOLD_EN
    logic                    fold_q;
    logic                    fold_in;
`endif

    function automatic logic signed [WIDTH-1:0] atan_deg(input logic [4:0] i);
        case (i)
            5'd0:    atan_deg = WIDTH'(2949120);
            5'd1:    atan_deg = WIDTH'(1740967);
            5'd2:    atan_deg = WIDTH'(919879);
            5'd3:    atan_deg = WIDTH'(466945);
            5'd4:    atan_deg = WIDTH'(234379);
            5'd5:    atan_deg = WIDTH'(117304);
            5'd6:    atan_deg = WIDTH'(58666);
            5'd7:    atan_deg = WIDTH'(29335);
            5'd8:    atan_deg = WIDTH'(14668);
            5'd9:    atan_deg = WIDTH'(7334);
            5'd10:   atan_deg = WIDTH'(3667);
            5'd11:   atan_deg = WIDTH'(1833);
            5'd12:   atan_deg = WIDTH'(917);
            5'd13:   atan_deg = WIDTH'(458);
            5'd14:   atan_deg = WIDTH'(229);
            5'd15:   atan_deg = WIDTH'(115);
            default: atan_deg = '0;
        endcase
    endfunction

    // Bring the requested angle into the +/-90 degree convergence range.
    always_comb begin
        angle_in = theta_deg;
`ifdef CORDIC_QUADRANT_FOLD_EN
        fold_in = 1'b0;
        if (theta_deg > DEG90) begin
            angle_in = DEG180 - theta_deg;
            fold_in  = 1'b1;
        end else if (theta_deg < -DEG90) begin
            angle_in = -DEG180 - theta_deg;
            fold_in  = 1'b1;
        end
`else
        if (theta_deg > DEG90)
            angle_in = DEG90;
        else if (theta_deg < -DEG90)
            angle_in = -DEG90;
`endif
    end

    // Folding across the y axis flips the sign of cosine only.
`ifdef CORDIC_QUADRANT_FOLD_EN
    assign x_res = fold_q ? -x : x;
`else
    assign x_res = x;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            z          <= '0;
            cnt        <= '0;
            mode_q     <= 1'b0;
            result_out <= '0;
            done       <= 1'b0;
`ifdef CORDIC_QUADRANT_FOLD_EN
            fold_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mode_q <= mode;
                        x      <= INV_K;
                        y      <= '0;
                        z      <= angle_in;
                        cnt    <= '0;
                        done   <= 1'b0;
                        state  <= ITER;
`ifdef CORDIC_QUADRANT_FOLD_EN
                        fold_q <= fold_in;
`endif
                    end
                end
                ITER: begin
                    if (cnt == 5'd16) begin
                        result_out <= mode_q ? x_res : y;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else begin
                        if (!z[WIDTH-1]) begin
                            x <= x - (y >>> cnt);
                            y <= y + (x >>> cnt);
                            z <= z - atan_deg(cnt);
                        end else begin
                            x <= x + (y >>> cnt);
                            y <= y - (x >>> cnt);
                            z <= z + atan_deg(cnt);
                        end
                        cnt <= cnt + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_top.sv
// Self-checking bench for cordic_top: directed angles, control corner cases and random
// angles against a real-arithmetic sin/cos model (honours CORDIC_QUADRANT_FOLD_EN).
module tb_cordic_top;
    localparam int WIDTH = 32;
    localparam int TOL   = 64;
    localparam real PI   = 3.14159265358979323846;

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic                    mode;
    logic signed [WIDTH-1:0] theta_deg;
    logic signed [WIDTH-1:0] result_out;
    logic                    done;

    int checks   = 0;
    int failures = 0;

    cordic_top #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .theta_deg  (theta_deg),
        .result_out (result_out),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp, input int tol);
        longint diff;
        checks++;
        diff = longint'(obs) - longint'(exp);
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Ideal sin/cos of the angle the block is expected to evaluate.
    function automatic int model(input int th, input bit m);
        real deg;
        real r;
        deg = real'(th) / 65536.0;
`ifndef CORDIC_QUADRANT_FOLD_EN
        if (deg > 90.0) deg = 90.0;
        if (deg < -90.0) deg = -90.0;
`endif
        r = m ? $cos(deg * PI / 180.0) : $sin(deg * PI / 180.0);
        r = r * 65536.0;
        return $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
    endfunction

    task automatic run_op(input bit m, input int th, input bit repulse, output int lat);
        @(negedge clk);
        mode      = m;
        theta_deg = th;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_clear", int'(done), 0, 0);
        lat = 0;
        while (!done && lat < 40) begin
            if (repulse && lat == 4) begin
                start     = 1'b1;
                mode      = ~m;
                theta_deg = -th + 12345;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic check_op(input string tag, input bit m, input int th, input bit repulse);
        int lat;
        run_op(m, th, repulse, lat);
        chk({tag, "_lat"}, lat, 17, 0);
        chk(tag, int'(result_out), model(th, m), TOL);
    endtask

    typedef struct {
        int th;
        bit m;
    } vec_t;

    vec_t dirs[$];

    initial begin
        int lat;
        int bad;
        int seen;
        int saved;
        int th;

        rst       = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        theta_deg = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", int'(done), 0, 0);
        chk("rst_result", int'(result_out), 0, 0);
        @(negedge clk);
        rst = 1'b0;

        dirs = '{'{0, 1'b0}, '{0, 1'b1},
                 '{1966080, 1'b0}, '{1966080, 1'b1}, '{-1966080, 1'b0},
                 '{2949120, 1'b0}, '{-2949120, 1'b0}, '{2949120, 1'b1},
                 '{5898240, 1'b0}, '{5898240, 1'b1},
                 '{-5898240, 1'b0}, '{-5898240, 1'b1},
                 '{9830400, 1'b0}, '{9830400, 1'b1},
                 '{-9830400, 1'b0}, '{-9830400, 1'b1},
                 '{-11796480, 1'b1}, '{11796479, 1'b0}};
        foreach (dirs[i])
            check_op($sformatf("dir%0d", i), dirs[i].m, dirs[i].th, 1'b0);

        check_op("repulse_sin30", 1'b0, 1966080, 1'b1);
        check_op("repulse_cos45", 1'b1, 2949120, 1'b1);

        // done and result_out must hold while inputs wander and start stays low
        check_op("pre_hold", 1'b0, 1966080, 1'b0);
        saved = int'(result_out);
        bad   = 0;
        repeat (10) begin
            @(negedge clk);
            mode      = 1'($urandom);
            theta_deg = $urandom;
            @(posedge clk);
            #1;
            if (int'(result_out) != saved || !done) bad++;
        end
        chk("hold", bad, 0, 0);

        // reset in the middle of an iteration run
        run_op(1'b1, 0, 1'b0, lat);
        chk("pre_rst_result", int'(result_out), 65536, TOL);
        @(negedge clk);
        mode      = 1'b0;
        theta_deg = 1966080;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_done", int'(done), 0, 0);
        chk("midrst_result", int'(result_out), 0, 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("no_done_after_rst", seen, 0, 0);
        check_op("after_rst", 1'b1, -1966080, 1'b0);

        for (int k = 0; k < 40; k++) begin
            th = int'($urandom_range(0, 23592959)) - 11796480;
            check_op($sformatf("rnd%0d", k), 1'($urandom), th, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
